// File: rtl/pong_pkg.sv
// Playfield geometry and paddle FSM encoding shared by the paddle controller,
// the Pong renderer and the collision logic.
package pong_pkg;

    localparam int SCREEN_H = 480;
    localparam int PADDLE_H = 64;
    localparam int COORD_W  = 10;

    // Lowest legal top-edge position, and the recentre position used at reset.
    localparam int YMAX    = SCREEN_H - PADDLE_H;
    localparam int YCENTER = YMAX / 2;

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } paddle_state_t;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Strobe inputs and paddle status outputs between the keypad decoder side
// (master) and the paddle controller (slave).
interface paddle_ctrl_if;
    import pong_pkg::*;

    logic               up;
    logic               down;
    logic [COORD_W-1:0] paddle_y;
    logic               moving;
    logic               at_top;
    logic               at_bottom;

    modport master (
        output up,
        output down,
        input  paddle_y,
        input  moving,
        input  at_top,
        input  at_bottom
    );

    modport slave (
        input  up,
        input  down,
        output paddle_y,
        output moving,
        output at_top,
        output at_bottom
    );

endinterface

// File: rtl/paddle_ctrl.sv
// Turns single-cycle up/down strobes into smooth STEP-pixel paddle moves,
// one pixel every TICK_DIV clocks, with a small same-direction queue.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int STEP        = 16,
    parameter int TICK_DIV    = 4,
    parameter int MAX_PENDING = 3
) (
    input  logic          clk,
    input  logic          rst,
    paddle_ctrl_if.slave  pif
);

    localparam int REM_W  = $clog2(STEP + 1);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(YMAX);
    localparam logic [COORD_W-1:0] Y_CENTER = COORD_W'(YCENTER);
    localparam logic [REM_W-1:0]   REM_STEP = REM_W'(STEP);
    localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PENDING);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);

    paddle_state_t      state;
    logic               dir;        // 0: toward y=0, 1: toward YMAX
    logic [REM_W-1:0]   remaining;
    logic [PEND_W-1:0]  pending;
    logic [DIV_W-1:0]   div;
    logic [COORD_W-1:0] paddle_y;
    logic               moving;
    logic               at_top;
    logic               at_bottom;

    logic               req;
    logic               dir_req;
    logic               same_req;
    logic               rev_req;
    logic               move_edge;
    logic               blocked;
    logic               step_px;
    logic [COORD_W-1:0] y_next;
    logic [REM_W-1:0]   rem_dec;
    logic [PEND_W:0]    eff;

    function automatic logic [PEND_W-1:0] sat_inc(input logic [PEND_W-1:0] p);
        return (p >= PEND_MAX) ? PEND_MAX : p + 1'b1;
    endfunction

    function automatic logic at_bound(input logic d, input logic [COORD_W-1:0] y);
        return d ? (y == Y_MAX) : (y == '0);
    endfunction

    always_comb begin
        req       = pif.up ^ pif.down;
        dir_req   = pif.down;
        same_req  = req && (dir_req == dir);
        rev_req   = req && (dir_req != dir);
        move_edge = (div == DIV_LAST);
        blocked   = at_bound(dir, paddle_y);
        // A reversal swallows a coinciding move edge, so no pixel moves then.
        step_px   = (state == MOVE) && !rev_req && move_edge && !blocked;
        y_next    = paddle_y;
        if (step_px) begin
            y_next = dir ? paddle_y + 1'b1 : paddle_y - 1'b1;
        end
        rem_dec   = remaining - 1'b1;
        eff       = {1'b0, pending} + {{PEND_W{1'b0}}, same_req};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dir       <= 1'b0;
            remaining <= '0;
            pending   <= '0;
            div       <= '0;
            paddle_y  <= Y_CENTER;
            moving    <= 1'b0;
            at_top    <= 1'b0;
            at_bottom <= 1'b0;
        end else begin
            paddle_y  <= y_next;
            at_top    <= (y_next == '0);
            at_bottom <= (y_next == Y_MAX);
            case (state)
                IDLE: begin
                    if (req && !at_bound(dir_req, paddle_y)) begin
                        dir       <= dir_req;
                        remaining <= REM_STEP;
                        div       <= '0;
                        pending   <= '0;
                        state     <= MOVE;
                        moving    <= 1'b1;
                    end
                end
                MOVE: begin
                    if (rev_req) begin
                        dir       <= ~dir;
                        remaining <= REM_STEP;
                        pending   <= '0;
                        div       <= '0;
                    end else begin
                        div <= move_edge ? '0 : div + 1'b1;
                        if (!move_edge) begin
                            if (same_req) pending <= sat_inc(pending);
                        end else if (blocked) begin
                            // Sitting on the bound: drop the rest of the move and the queue.
                            pending   <= '0;
                            remaining <= '0;
                            state     <= IDLE;
                            moving    <= 1'b0;
                        end else if (rem_dec != '0) begin
                            remaining <= rem_dec;
                            if (same_req) pending <= sat_inc(pending);
                        end else if (eff != '0) begin
                            // Step finished: chain straight into the next queued step.
                            remaining <= REM_STEP;
                            pending   <= PEND_W'(eff - 1'b1);
                        end else begin
                            remaining <= '0;
                            state     <= IDLE;
                            moving    <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pif.paddle_y  = paddle_y;
    assign pif.moving    = moving;
    assign pif.at_top    = at_top;
    assign pif.at_bottom = at_bottom;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: single steps, queue saturation, reversal,
// bound clamping, simultaneous strobes and asynchronous reset.
module tb_paddle_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    paddle_ctrl_if pif ();

    paddle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic u, input logic d);
        pif.up   = u;
        pif.down = d;
        @(negedge clk);
        pif.up   = 1'b0;
        pif.down = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (pif.moving && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, pif.moving, 0);
    endtask

    initial begin
        int steps;
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        pif.up   = 1'b0;
        pif.down = 1'b0;

        // 1: asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_y", pif.paddle_y, 208);
        chk("rst_moving", pif.moving, 0);
        chk("rst_top", pif.at_top, 0);
        chk("rst_bot", pif.at_bottom, 0);
        @(negedge clk);
        rst = 1'b0;

        // 2: single up step
        strobe(1'b1, 1'b0);
        chk("up_moving_e0", pif.moving, 1);
        cycles(1);
        chk("up_moving_e1", pif.moving, 1);
        cycles(2);
        chk("up_y_e3", pif.paddle_y, 208);
        cycles(1);
        chk("up_y_e4", pif.paddle_y, 207);
        cycles(59);
        chk("up_y_e63", pif.paddle_y, 193);
        chk("up_moving_e63", pif.moving, 1);
        cycles(1);
        chk("up_y_e64", pif.paddle_y, 192);
        chk("up_moving_e64", pif.moving, 0);

        // 3: five down strobes, queue saturates at three
        do_reset();
        pif.down = 1'b1;
        cycles(5);
        pif.down = 1'b0;
        cycles(251);
        chk("q_y_e255", pif.paddle_y, 271);
        chk("q_moving_e255", pif.moving, 1);
        cycles(1);
        chk("q_y_e256", pif.paddle_y, 272);
        chk("q_moving_e256", pif.moving, 0);

        // 4: reversal mid-step
        do_reset();
        strobe(1'b1, 1'b0);
        cycles(20);
        chk("rev_y_e20", pif.paddle_y, 203);
        strobe(1'b0, 1'b1);
        chk("rev_y_e21", pif.paddle_y, 203);
        cycles(63);
        chk("rev_y_e84", pif.paddle_y, 218);
        chk("rev_moving_e84", pif.moving, 1);
        cycles(1);
        chk("rev_y_e85", pif.paddle_y, 219);
        chk("rev_moving_e85", pif.moving, 0);

        // 5: clamp at the top, then at the bottom via a queued overshoot
        do_reset();
        steps = 0;
        while (pif.paddle_y != 0 && steps < 20) begin
            strobe(1'b1, 1'b0);
            wait_idle("top_idle", 100);
            steps++;
        end
        chk("top_steps", steps, 13);
        chk("top_y", pif.paddle_y, 0);
        chk("top_flag", pif.at_top, 1);
        strobe(1'b1, 1'b0);
        cycles(1);
        chk("top_ign_moving", pif.moving, 0);
        chk("top_ign_y", pif.paddle_y, 0);

        for (int b = 0; b < 7; b++) begin
            pif.down = 1'b1;
            cycles(4);
            pif.down = 1'b0;
            wait_idle("bot_idle", 400);
            if (b == 5) chk("bot_y_b5", pif.paddle_y, 384);
        end
        chk("bot_y", pif.paddle_y, 416);
        chk("bot_flag", pif.at_bottom, 1);
        chk("bot_top_flag", pif.at_top, 0);
        strobe(1'b0, 1'b1);
        cycles(1);
        chk("bot_ign_moving", pif.moving, 0);
        chk("bot_ign_y", pif.paddle_y, 416);

        // 6: simultaneous strobes ignored in IDLE and MOVE
        do_reset();
        strobe(1'b1, 1'b1);
        cycles(1);
        chk("both_idle_moving", pif.moving, 0);
        chk("both_idle_y", pif.paddle_y, 208);
        strobe(1'b1, 1'b0);
        cycles(9);
        strobe(1'b1, 1'b1);
        chk("both_move_y_e10", pif.paddle_y, 206);
        cycles(53);
        chk("both_move_y_e63", pif.paddle_y, 193);
        cycles(1);
        chk("both_move_y_e64", pif.paddle_y, 192);
        chk("both_move_moving", pif.moving, 0);

        // 6: asynchronous reset in the middle of a move
        do_reset();
        strobe(1'b1, 1'b0);
        cycles(32);
        chk("arst_pre_y", pif.paddle_y, 200);
        chk("arst_pre_moving", pif.moving, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_y", pif.paddle_y, 208);
        chk("arst_moving", pif.moving, 0);
        chk("arst_top", pif.at_top, 0);
        chk("arst_bot", pif.at_bottom, 0);
        @(negedge clk);
        rst = 1'b0;
        cycles(8);
        chk("arst_hold_y", pif.paddle_y, 208);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Downstream consumer of the keypad decoder's single-cycle up/down strobes. It converts each strobe into a smooth paddle move of STEP pixels, at one pixel per TICK_DIV clocks. It queues repeated requests, handles reversals and clamps to the playfield. Its output paddle_y feeds the Pong renderer and the collision logic.

Parameters:
SCREEN_H, 480, playfield height in pixels
PADDLE_H, 64, paddle height in pixels
STEP, 16, pixels moved per accepted strobe
TICK_DIV, 4, clocks per 1-pixel move (must be >= 1)
MAX_PENDING, 3, maximum queued same-direction steps
COORD_W, 10, width of the y coordinate

Ports:
clk  input  1  system clock, the only clock
rst  input  1  reset, asynchronous, active-high
up  input  1  single-cycle strobe: move paddle toward y=0
down  input  1  single-cycle strobe: move paddle toward YMAX
paddle_y  output  COORD_W  top edge of the paddle, registered
moving  output  1  high while the state machine is in MOVE
at_top  output  1  paddle_y == 0
at_bottom  output  1  paddle_y == YMAX

Behaviour:
- Derived values: YMAX = SCREEN_H - PADDLE_H (416); YCENTER = YMAX/2 (208).
- Reset state (asynchronous): paddle_y=208, state=IDLE, dir=0, remaining=0, pending=0, div=0, moving=0, at_top=0, at_bottom=0.
- All outputs are registered. at_top and at_bottom are derived from the next value of paddle_y, so they are valid in the same cycle as paddle_y.
- up and down are sampled on every rising clk edge.
- Strobe classes:
  - up && down: ignored in every state.
  - up xor down: a "request" in direction dir_req.
- IDLE:
  - A request toward a bound the paddle already sits on is ignored; stay in IDLE.
  - Otherwise: dir <= dir_req, remaining <= STEP, div <= 0, pending <= 0, enter MOVE.
  - moving goes high on the cycle after the strobe.
- MOVE, per cycle:
  - div counts 0..TICK_DIV-1 and wraps. A move happens on the edge where div == TICK_DIV-1.
  - First pixel change occurs TICK_DIV edges after the strobe edge. A full step takes STEP*TICK_DIV cycles (64 with defaults).
  - Same-direction request: pending <= min(pending+1, MAX_PENDING). Extra requests are dropped.
  - Opposite-direction request (reversal), which takes priority over a move edge in the same cycle:
    - dir flips, remaining <= STEP, pending <= 0, div <= 0.
    - No pixel moves that cycle.
  - Move edge without reversal:
    - If paddle_y is at the bound in dir: pending <= 0, remaining <= 0, go to IDLE. No wrap-around, no overshoot.
    - Otherwise paddle_y moves by 1 toward dir and remaining decrements.
    - If remaining reaches 0, use eff = pending + (same-direction request this cycle):
      - eff > 0: remaining <= STEP, pending <= eff-1, stay in MOVE.
      - eff = 0: go to IDLE.
- Arithmetic: paddle_y is unsigned COORD_W bits and never leaves 0..YMAX. remaining is clog2(STEP+1) bits; pending is clog2(MAX_PENDING+1) bits.
- Reset asserted mid-move immediately recentres the paddle to 208 and clears the queue, with no clock edge needed.

Decomposition:
- pong_pkg holds SCREEN_H, PADDLE_H, COORD_W, the YMAX/YCENTER localparams and the state encoding (IDLE=0, MOVE=1).
- These constants are shared with the renderer and collision blocks.
- Single module; no sub-module is warranted. The divider is one counter inside the FSM.

Test Plan:
1. Assert rst without any clk edge -> paddle_y=208, moving=0, at_top=0, at_bottom=0.
2. One up strobe at edge 0 -> moving=1 after edge 1; paddle_y=207 after edge 4; paddle_y=192 and moving=0 after edge 64.
3. Five down strobes on consecutive cycles -> pending capped at 3, four steps total; paddle_y=272 after edge 256, then IDLE.
4. Up strobe at edge 0, down strobe at edge 21 (paddle_y=203) -> reversal; paddle_y=219 after edge 85, then moving=0.
5. Strobe up repeatedly from 208 until paddle_y=0 -> at_top=1, the FSM returns to IDLE at the bound. A further up strobe leaves moving=0 and paddle_y=0. Mirror the test at the bottom: paddle_y=416, at_bottom=1.
6. up and down asserted in the same cycle, in both IDLE and MOVE -> no state change. Assert rst mid-move at paddle_y=200 -> paddle_y=208 and moving=0 asynchronously.
